// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit: sequential instruction fetch feeding decode through a DEPTH-entry prefetch queue
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counters.
module prefetch_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  branch_jump_address,
    input  logic                   branch_or_jump,
    input  logic                   data_mem_busywait,
    input  logic                   id_ready,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic                   imem_read,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_busywait,
    output logic                   if_valid,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic [ADDR_WIDTH-1:0]  if_pc_plus4,
    output logic [INSTR_WIDTH-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] RV = RESET_VECTOR & ~ADDR_WIDTH'(3);

    typedef enum logic {FETCH, DROP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fpc, fpc_n, redir_pc, target;
    logic [ADDR_WIDTH-1:0]   pc_q [DEPTH];
    logic [INSTR_WIDTH-1:0]  instr_q [DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count, count_n;
    logic                    hit, miss, push, pop, drop_done;

    // Handshake decode, next queue occupancy and registered-storage head outputs
    always_comb begin
        target      = branch_jump_address & ~ADDR_WIDTH'(3);
        hit         = imem_read & ~imem_busywait;
        miss        = imem_read & imem_busywait;
        push        = (state == FETCH) & hit & ~branch_or_jump;
        drop_done   = (state == DROP) & hit;
        if_valid    = count != '0;
        pop         = if_valid & id_ready & ~data_mem_busywait & ~branch_or_jump;
        count_n     = count + CW'(push) - CW'(pop);
        fpc_n       = push ? fpc + ADDR_WIDTH'(4) : fpc;
        if_pc       = if_valid ? pc_q[rd_ptr] : '0;
        if_instr    = if_valid ? instr_q[rd_ptr] : '0;
        if_pc_plus4 = if_valid ? if_pc + ADDR_WIDTH'(4) : '0;
    end

    // Fetch FSM: request issue, queue pointers and redirect/drop handling; the icache request is held during a miss
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            fpc       <= RV;
            redir_pc  <= RV;
            imem_addr <= RV;
            imem_read <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (branch_or_jump) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fpc      <= target;
            redir_pc <= target;
            if (miss) begin
                state <= DROP;
            end else begin
                state     <= FETCH;
                imem_addr <= target;
                imem_read <= 1'b1;
            end
        end else if (state == DROP) begin
            if (drop_done) begin
                state     <= FETCH;
                fpc       <= redir_pc;
                imem_addr <= redir_pc;
                imem_read <= 1'b1;
            end
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push);
            count  <= count_n;
            fpc    <= fpc_n;
            if (!miss) begin
                imem_addr <= fpc_n;
                imem_read <= count_n < CW'(DEPTH);
            end
        end
    end

    // Queue storage; contents are only observed while the entry is counted as valid
    always_ff @(posedge clock) begin
        if (push) begin
            pc_q[wr_ptr]    <= fpc;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: pushes, plus entries lost to flushes and misses abandoned by a redirect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + (branch_or_jump ? 32'(count) : 32'd0) + 32'(drop_done);
        end
    end
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb_prefetch_fetch_unit: directed + randomized scoreboard bench for prefetch_fetch_unit
module tb_prefetch_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] branch_jump_address;
    logic        branch_or_jump;
    logic        data_mem_busywait;
    logic        id_ready;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] pf0, pl0;
`endif

    int          passed = 0;
    int          total = 0;
    int          retired = 0;
    bit          prev_redir = 0;
    logic [31:0] exp_q[$];
    int          miss_left = 0;
    bit          miss_armed = 0;
    logic [31:0] miss_addr;
    int          miss_len;
    bit          rand_mode = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = imem_busywait ? 32'hDEAD_BEEF : mem(imem_addr);

    prefetch_fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
        .clock(clk),
        .reset(rst_n),
        .branch_jump_address(branch_jump_address),
        .branch_or_jump(branch_or_jump),
        .data_mem_busywait(data_mem_busywait),
        .id_ready(id_ready),
        .imem_addr(imem_addr),
        .imem_read(imem_read),
        .imem_rdata(imem_rdata),
        .imem_busywait(imem_busywait),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .if_instr(if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference stream: after a redirect to T the retired PCs are exactly T, T+4, T+8, ...
    task automatic fill_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic redirect(input logic [31:0] t);
        branch_or_jump = 1'b1;
        branch_jump_address = t;
        fill_exp(t & ~32'h3);
    endtask

    // One clock: advance, clear the one-shot strobe, then run the icache miss model
    task automatic step();
        @(posedge clk);
        #1;
        branch_or_jump = 1'b0;
        if (miss_left > 0) begin
            imem_busywait = 1'b1;
            miss_left--;
        end else if (imem_busywait) begin
            imem_busywait = 1'b0;
        end else begin
            int len = 0;
            if (imem_read && miss_armed && imem_addr == miss_addr) begin
                len = miss_len;
                miss_armed = 0;
            end else if (imem_read && rand_mode && $urandom_range(0, 99) < 15) begin
                len = $urandom_range(1, 4);
            end
            if (len > 0) begin
                imem_busywait = 1'b1;
                miss_left = len - 1;
            end
        end
    endtask

    // Monitor: every retirement is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_redir) chk("flush_valid", {31'b0, if_valid}, 32'h0);
            prev_redir = branch_or_jump;
            if (!if_valid) chk("empty_zero", if_pc | if_pc_plus4 | if_instr, 32'h0);
            if (if_valid && id_ready && !data_mem_busywait && !branch_or_jump) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'h1, 32'h0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("ret_pc", if_pc, e);
                    chk("ret_pc4", if_pc_plus4, e + 32'h4);
                    chk("ret_instr", if_instr, mem(e));
                end
                retired++;
            end
        end
    end

    initial begin
        int n, pushes, r0;
        logic [31:0] t;
        rst_n = 1'b0;
        id_ready = 1'b1;
        data_mem_busywait = 1'b0;
        branch_or_jump = 1'b0;
        branch_jump_address = '0;
        imem_busywait = 1'b0;
        fill_exp(32'h0);
        repeat (3) @(negedge clk);
        chk("rst_read", {31'b0, imem_read}, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'h0);
        chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
        // Reset vector fetch, then a 5-cycle miss at 0x8
        miss_armed = 1;
        miss_addr = 32'h8;
        miss_len = 5;
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            @(negedge clk);
            n++;
        end while (!imem_read && n < 10);
        chk("first_read", {31'b0, imem_read}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        step();
        @(negedge clk);
        chk("addr_4", imem_addr, 32'h4);
        chk("head_valid", {31'b0, if_valid}, 32'h1);
        chk("head_pc", if_pc, 32'h0);
        chk("head_pc4", if_pc_plus4, 32'h4);
        step();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("miss_hold_addr", imem_addr, 32'h8);
            chk("miss_hold_read", {31'b0, imem_read}, 32'h1);
        end
        step();
        @(negedge clk);
        chk("after_miss_addr", imem_addr, 32'hC);
        // Decode stalled from an empty queue: exactly DEPTH pushes then no request
        step();
        id_ready = 1'b0;
        redirect(32'h40);
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if (i == 0) chk("redir_flushed", {31'b0, if_valid}, 32'h0);
            if (i == 1) chk("redir_latency_pc", if_valid ? if_pc : 32'hFFFF_FFFF, 32'h40);
            if (imem_read && !imem_busywait) pushes++;
        end
        chk("full_pushes", 32'(pushes), 32'(DEPTH));
        chk("full_no_read", {31'b0, imem_read}, 32'h0);
        step();
        id_ready = 1'b1;
        repeat (8) step();
        // Redirect during a miss: the missed word is dropped
        step();
        redirect(32'h10);
        miss_armed = 1;
        miss_addr = 32'h10;
        miss_len = 6;
        step();
        @(negedge clk);
        chk("miss10_addr", imem_addr, 32'h10);
        step();
        redirect(32'h100);
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        pl0 = perf_flushed;
`endif
        step();
        @(negedge clk);
        chk("drop_hold_addr", imem_addr, 32'h10);
        chk("drop_hold_read", {31'b0, imem_read}, 32'h1);
        n = 0;
        while (imem_addr != 32'h100 && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("drop_next_addr", imem_addr, 32'h100);
        step();
        @(negedge clk);
        chk("drop_head_pc", if_valid ? if_pc : 32'hFFFF_FFFF, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_drop", perf_flushed - pl0, 32'h1);
`endif
        // Two redirects during one miss: the last one wins
        step();
        redirect(32'h20);
        miss_armed = 1;
        miss_addr = 32'h20;
        miss_len = 6;
        step();
        step();
        redirect(32'h600);
        step();
        step();
        redirect(32'h700);
        n = 0;
        @(negedge clk);
        while (imem_addr == 32'h20 && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("last_redirect_wins", imem_addr, 32'h700);
        repeat (4) step();
        // Redirect with a full queue and a simultaneous pop
        step();
        id_ready = 1'b0;
        redirect(32'h300);
        repeat (8) step();
        @(negedge clk);
        chk("full_before_flush", {31'b0, if_valid & ~imem_read}, 32'h1);
        step();
        id_ready = 1'b1;
        redirect(32'h400);
        step();
        @(negedge clk);
        chk("flush_full_valid", {31'b0, if_valid}, 32'h0);
        chk("flush_full_addr", imem_addr, 32'h400);
        chk("flush_full_read", {31'b0, imem_read}, 32'h1);
        repeat (4) step();
        // Back-end stall holds the head
        step();
        id_ready = 1'b0;
        redirect(32'h800);
        repeat (6) step();
        step();
        id_ready = 1'b1;
        data_mem_busywait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dmb_hold", if_pc, 32'h800);
            step();
        end
        data_mem_busywait = 1'b0;
        @(negedge clk);
        chk("dmb_release_pc", if_pc, 32'h800);
        step();
        @(negedge clk);
        chk("dmb_advance", if_pc, 32'h804);
        // Flush of three queued entries, then a target at the top of the address space
        step();
        id_ready = 1'b0;
        redirect(32'h500);
        step();
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        pf0 = perf_fetched;
        pl0 = perf_flushed;
`endif
        step();
        step();
        step();
        redirect(32'hFFFF_FFFC);
        step();
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched_3", perf_fetched - pf0, 32'h3);
        chk("perf_flushed_3", perf_flushed - pl0, 32'h3);
`endif
        step();
        @(negedge clk);
        chk("wrap_pc", if_valid ? if_pc : 32'h0, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h0);
        step();
        id_ready = 1'b1;
        repeat (6) step();
        // Randomized traffic against the stream model
        rand_mode = 1;
        r0 = retired;
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            id_ready = $urandom_range(0, 9) < 7;
            data_mem_busywait = $urandom_range(0, 99) < 15;
            n++;
            if (n >= 100 || $urandom_range(0, 99) < 4) begin
                t = $urandom();
                if ($urandom_range(0, 1) == 1) t = t & 32'h3FF;
                redirect(t);
                n = 0;
            end
        end
        rand_mode = 0;
        step();
        data_mem_busywait = 1'b0;
        id_ready = 1'b1;
        repeat (10) step();
        chk("liveness", {31'b0, (retired - r0) >= 500}, 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
